// File: rtl/timer_clock_select_if.sv
// Control and count-output bundle between the timer control register, the clock
// select/prescaler unit and the 8-bit timer counter.
interface timer_clock_select_if #(
    parameter int PRESCALER_WIDTH = 10
);
    logic [2:0]                 ClockSelect;
    logic                       CascadeEnable;
    logic                       CascadeEvent;
    logic                       PrescalerReset;
    logic                       ExtPin;
    logic                       CountTick;
    logic [PRESCALER_WIDTH-1:0] PrescalerValue;

    modport master (
        output ClockSelect,
        output CascadeEnable,
        output CascadeEvent,
        output PrescalerReset,
        output ExtPin,
        input  CountTick,
        input  PrescalerValue
    );

    modport slave (
        input  ClockSelect,
        input  CascadeEnable,
        input  CascadeEvent,
        input  PrescalerReset,
        input  ExtPin,
        output CountTick,
        output PrescalerValue
    );
endinterface

// File: rtl/timer_clock_select.sv
// Clock-source and prescaler unit: turns the selected source (prescaled clock,
// synchronised T pin edge or cascade event) into a single-cycle CountTick.
module timer_clock_select #(
    parameter int PRESCALER_WIDTH = 10,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    timer_clock_select_if.slave  bus
);

    localparam int ARM_COUNT = SYNC_STAGES + 1;
    localparam int ARM_W     = $clog2(ARM_COUNT + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_COUNT);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
    localparam logic [PRESCALER_WIDTH-1:0] PRESCALER_ONE = PRESCALER_WIDTH'(1);

    logic [PRESCALER_WIDTH-1:0] prescaler_r;
    logic [SYNC_STAGES-1:0]     sync_r;
    logic                       ext_hist_r;
    logic                       casc_hist_r;
    logic [ARM_W-1:0]           arm_r;
    logic                       tick_r;

    logic                       stopped_s;
    logic                       armed_s;
    logic                       ext_rise_s;
    logic                       ext_fall_s;
    logic                       casc_rise_s;
    logic                       tick_next_s;

    assign stopped_s   = (bus.ClockSelect == 3'b000) && !bus.CascadeEnable;
    assign armed_s     = (arm_r == ARM_LAST);
    assign ext_rise_s  = sync_r[SYNC_STAGES-1] & ~ext_hist_r & armed_s;
    assign ext_fall_s  = ~sync_r[SYNC_STAGES-1] & ext_hist_r & armed_s;
    assign casc_rise_s = bus.CascadeEvent & ~casc_hist_r;

    // Tick source selection; prescaled taps fire when the low k prescaler bits are all ones
    always_comb begin
        tick_next_s = 1'b0;
        if (bus.CascadeEnable) begin
            tick_next_s = casc_rise_s;
        end else begin
            case (bus.ClockSelect)
                3'b000:  tick_next_s = 1'b0;
                3'b001:  tick_next_s = 1'b1;
                3'b010:  tick_next_s = (&prescaler_r[2:0]) && !bus.PrescalerReset;
                3'b011:  tick_next_s = (&prescaler_r[5:0]) && !bus.PrescalerReset;
                3'b100:  tick_next_s = (&prescaler_r[7:0]) && !bus.PrescalerReset;
                3'b101:  tick_next_s = (&prescaler_r[9:0]) && !bus.PrescalerReset;
                3'b110:  tick_next_s = ext_fall_s;
                3'b111:  tick_next_s = ext_rise_s;
                default: tick_next_s = 1'b0;
            endcase
        end
    end

    // All state: prescaler, pin synchroniser/history, cascade history, arm counter, tick
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            prescaler_r <= '0;
            sync_r      <= '0;
            ext_hist_r  <= 1'b0;
            casc_hist_r <= 1'b0;
            arm_r       <= '0;
            tick_r      <= 1'b0;
        end else begin
            if (bus.PrescalerReset) begin
                prescaler_r <= '0;
            end else if (stopped_s) begin
                prescaler_r <= prescaler_r;
            end else begin
                prescaler_r <= prescaler_r + PRESCALER_ONE;
            end
            // Synchroniser and histories run in every mode so mode switches see no stale edge
            sync_r      <= {sync_r[SYNC_STAGES-2:0], bus.ExtPin};
            ext_hist_r  <= sync_r[SYNC_STAGES-1];
            casc_hist_r <= bus.CascadeEvent;
            if (armed_s) begin
                arm_r <= arm_r;
            end else begin
                arm_r <= arm_r + ARM_ONE;
            end
            tick_r <= tick_next_s;
        end
    end

    assign bus.CountTick      = tick_r;
    assign bus.PrescalerValue = prescaler_r;

endmodule

// File: tb/tb_timer_clock_select.sv
// Directed bench for timer_clock_select: prescaled, external, cascade, stop and reset behaviour.
module tb_timer_clock_select;

    localparam int PW = 10;

    logic Clock;
    logic ResetN;
    int   n_checks;
    int   n_errors;

    timer_clock_select_if #(.PRESCALER_WIDTH(PW)) bus ();

    timer_clock_select #(.PRESCALER_WIDTH(PW), .SYNC_STAGES(2)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ResetN = 1'b0;
        bus.ClockSelect    = 3'b010;
        bus.CascadeEnable  = 1'b0;
        bus.CascadeEvent   = 1'b0;
        bus.PrescalerReset = 1'b0;
        bus.ExtPin         = 1'b0;
        step();
        step();
        check("reset_tick", {31'd0, bus.CountTick}, 32'd0);
        check("reset_presc", 32'(bus.PrescalerValue), 32'd0);

        // /8: ticks after edges 8,16,24,32,40
        ResetN = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            check($sformatf("div8_e%0d", e), {31'd0, bus.CountTick}, (e % 8 == 0) ? 32'd1 : 32'd0);
        end
        check("div8_presc40", 32'(bus.PrescalerValue), 32'd40);

        // /1: tick every cycle, PrescalerReset ignored
        bus.ClockSelect = 3'b001;
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            bus.PrescalerReset = (e == 3) ? 1'b1 : 1'b0;
            step();
            check($sformatf("div1_e%0d", e), {31'd0, bus.CountTick}, 32'd1);
        end
        bus.PrescalerReset = 1'b0;

        // /8 with PrescalerReset at edge 5: ticks after 13 and 21
        bus.ClockSelect = 3'b010;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            bus.PrescalerReset = (e == 5) ? 1'b1 : 1'b0;
            step();
            check($sformatf("prst_e%0d", e), {31'd0, bus.CountTick},
                  (e == 13 || e == 21) ? 32'd1 : 32'd0);
            if (e == 5) check("prst_presc5", 32'(bus.PrescalerValue), 32'd0);
        end
        bus.PrescalerReset = 1'b0;

        // /64 and /256
        bus.ClockSelect = 3'b011;
        do_reset();
        for (int e = 1; e <= 128; e++) begin
            step();
            check($sformatf("div64_e%0d", e), {31'd0, bus.CountTick}, (e % 64 == 0) ? 32'd1 : 32'd0);
        end
        bus.ClockSelect = 3'b100;
        do_reset();
        for (int e = 1; e <= 512; e++) begin
            step();
            check($sformatf("div256_e%0d", e), {31'd0, bus.CountTick}, (e % 256 == 0) ? 32'd1 : 32'd0);
        end

        // /1024: ticks after 1024 and 2048, prescaler wraps 1023 -> 0
        bus.ClockSelect = 3'b101;
        do_reset();
        for (int e = 1; e <= 2048; e++) begin
            step();
            check($sformatf("div1024_e%0d", e), {31'd0, bus.CountTick},
                  (e == 1024 || e == 2048) ? 32'd1 : 32'd0);
            if (e == 1023) check("wrap_1023", 32'(bus.PrescalerValue), 32'd1023);
            if (e == 1024) check("wrap_0", 32'(bus.PrescalerValue), 32'd0);
        end

        // External rising then falling
        bus.ClockSelect = 3'b111;
        bus.ExtPin = 1'b0;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            if (e >= 35) bus.ClockSelect = 3'b110;
            bus.ExtPin = ((e >= 20 && e <= 29) || (e >= 35 && e <= 39)) ? 1'b1 : 1'b0;
            step();
            check($sformatf("ext_e%0d", e), {31'd0, bus.CountTick},
                  (e == 22 || e == 42) ? 32'd1 : 32'd0);
        end
        bus.ExtPin = 1'b0;

        // Cascade: event high at edges 10-12, one tick after 10; prescaler keeps running
        bus.ClockSelect   = 3'b000;
        bus.CascadeEnable = 1'b1;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            bus.CascadeEvent = (e >= 10 && e <= 12) ? 1'b1 : 1'b0;
            step();
            check($sformatf("casc_e%0d", e), {31'd0, bus.CountTick}, (e == 10) ? 32'd1 : 32'd0);
        end
        check("casc_presc16", 32'(bus.PrescalerValue), 32'd16);
        bus.CascadeEvent  = 1'b0;
        bus.CascadeEnable = 1'b0;

        // Pin held high through reset gives no tick
        bus.ClockSelect = 3'b111;
        bus.ExtPin = 1'b1;
        ResetN = 1'b0;
        step();
        step();
        ResetN = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("arm_e%0d", e), {31'd0, bus.CountTick}, 32'd0);
        end
        check("arm_presc10", 32'(bus.PrescalerValue), 32'd10);

        // /8 from prescaler 10: would tick at edge 16, but reset lands there
        bus.ClockSelect = 3'b010;
        for (int e = 11; e <= 15; e++) begin
            step();
            check($sformatf("midrun_e%0d", e), {31'd0, bus.CountTick}, 32'd0);
        end
        ResetN = 1'b0;
        step();
        check("midrst_tick", {31'd0, bus.CountTick}, 32'd0);
        check("midrst_presc", 32'(bus.PrescalerValue), 32'd0);
        ResetN = 1'b1;

        // Stop mode freezes the prescaler; resuming /8 ticks on natural alignment
        for (int e = 1; e <= 5; e++) step();
        check("pre_stop_presc", 32'(bus.PrescalerValue), 32'd5);
        bus.ClockSelect = 3'b000;
        for (int e = 1; e <= 20; e++) begin
            step();
            check($sformatf("stop_tick%0d", e), {31'd0, bus.CountTick}, 32'd0);
        end
        check("stop_presc", 32'(bus.PrescalerValue), 32'd5);
        bus.ClockSelect = 3'b010;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("resume_e%0d", e), {31'd0, bus.CountTick}, (e == 3) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
